uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver stage that consumes the asynchronous line driven by the transmit side of a UART link and presents each received byte on a parallel bus. It synchronises the incoming `rx` line and detects the start bit. It samples each data bit at mid-bit using a clock-cycle divisor, then checks the stop bit. Each byte is delivered with a one-cycle strobe to the command/decoder logic downstream. It shares the baud-divisor constants (`baudgen.vh`) with the transmitter so both ends run the same bit time.

## Interface
- `BAUD`, default `` `B9600 ``: clock cycles per bit, from `baudgen.vh`. Must be even and ≥ 8.
- `clk`, input, 1: system clock (100 MHz).
- `rstn`, input, 1: reset, synchronous, active-low.
- `rx`, input, 1: asynchronous serial line; idles high.
- `data`, output, 8: last correctly framed byte. Registered; holds until the next good frame.
- `rcv`, output, 1: one-cycle pulse; `data` is valid in the same cycle.
- `busy`, output, 1: high from start-bit detection until the stop-bit decision.
- `ferr`, output, 1: one-cycle pulse when the stop bit samples 0.
- `perr`, output, 1: one-cycle pulse on parity mismatch; constant 0 when parity is compiled out.

## Operation
- **Synchroniser:** 2-FF chain on `rx` produces `rx_s`. Both FFs reset to 1.
- **Divisor counter:** `div_cnt`, `$clog2(BAUD)` bits. Cleared on every state change. Counts `0..BAUD-1` and wraps.
- **Shift register:** `shifter`, LSB first. Each sample shifts in at the MSB, so after 8 samples `shifter` = byte.
- **IDLE:** `busy` = 0. Move to START when `rx_s` = 0.
- **START:** when `div_cnt` = BAUD/2−1, sample `rx_s`.
  - If 0: go to RECV and clear bit counter `bitc`.
  - If 1: glitch; return to IDLE with no pulse.
- **RECV:** each time `div_cnt` = BAUD−1, sample `rx_s` into `shifter` and increment `bitc`. After 8 samples go to STOP, or to PAR when parity is enabled.
- **PAR:** at `div_cnt` = BAUD−1, sample the parity bit and go to STOP.
- **STOP:** at `div_cnt` = BAUD−1, sample the stop bit, then return to IDLE.
  - Stop = 1 and parity OK: `data` ← `shifter`, pulse `rcv`.
  - Stop = 1 and parity bad: pulse `perr`. `data` is not updated.
  - Stop = 0: pulse `ferr`. `data` is not updated. If both errors occur, only `ferr` pulses.
- **Back-to-back frames:** the block returns to IDLE at mid-stop-bit. A start edge arriving immediately after the stop bit is therefore captured.
- **Break condition:** if `rx_s` is still 0 in IDLE after a framing error, it is treated as a new start bit. There is no special break handling.

## Timing
- **Reset values:** `data` = 0x00; `rcv`, `ferr`, `perr`, `busy` = 0; state = IDLE; synchroniser = 1.
- **Reset mid-frame:** while `rstn` = 0 all outputs hold their reset values. After release the block is in IDLE. A low level on `rx` at that point is taken as a start bit.
- **Cycle reference:** cycle 0 is the first `clk` edge that registers `rx` = 0 in the first synchroniser FF.
- **`busy`** rises at cycle 3.
- **`rcv`/`ferr`/`perr`** pulse exactly 2 + BAUD/2 + 9·BAUD cycles after cycle 0 without parity. Add BAUD with parity.
- **Minimum low pulse:** the start bit must stay low for more than BAUD/2 cycles to be accepted.
- **No backpressure:** the consumer must latch `data` on `rcv`. `data` stays stable for at least 9·BAUD cycles afterwards.
- **Output pulses** (`rcv`, `ferr`, `perr`) are mutually exclusive and at most one per frame.

## Configuration
- **`UART_RX_PARITY_EN` defined:** the frame is start + 8 data + even parity + stop. The PAR state is present.
  - Even parity: XOR of the 8 data bits and the parity bit must be 0.
  - On mismatch, `perr` pulses and `rcv` is suppressed.
- **`UART_RX_PARITY_EN` undefined:**
  - PAR state and parity logic are absent.
  - `perr` is tied to 0.
  - The frame is 8N1.

## Structure
- **Shared header `uart_pkg.vh`:**
  - State encodings `RX_IDLE`/`RX_START`/`RX_RECV`/`RX_PAR`/`RX_STOP`.
  - Frame constants `UART_DATA_BITS` = 8.
  - Includes `baudgen.vh`.
- **Sub-module `uart_rx_sync`:** the 2-FF synchroniser with reset-to-1. It is reusable by other asynchronous inputs.
- **Divisor:** kept inline, because of the half-period phase for the start bit.

## Test plan
Bench uses BAUD = 16.
- **Single frame:** send 0x55 as 8N1 → `rcv` pulses once, `data` = 0x55, `ferr` = 0. Pulse lands at cycle 2 + 8 + 144 = 154.
- **Back-to-back frames:** send 0xA3 then 0x0F with no idle gap → two `rcv` pulses 160 cycles apart, `data` = 0xA3 then 0x0F.
- **Glitch rejection:** drive `rx` low for 4 cycles, then high → no `rcv`/`ferr`; `busy` returns to 0 by cycle 12.
- **Framing error:** send 0x3C with stop bit = 0 → `ferr` pulse at cycle 154, `rcv` = 0, `data` keeps its previous value.
- **Reset mid-frame:** assert `rstn` = 0 for 2 cycles mid-way through bit 4 → outputs return to reset values and no pulse occurs. A following clean 0x81 frame is received correctly.
- **Parity (`UART_RX_PARITY_EN`):**
  - 0x07 with parity bit 1 → `rcv`, `data` = 0x07.
  - 0x07 with parity bit 0 → `perr` pulse, no `rcv`.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART receive constants: baud divisors (clock cycles per bit at 100 MHz),
// frame size and receiver state encoding.
package uart_rx_pkg;

    localparam int B115200 = 868;
    localparam int B57600  = 1736;
    localparam int B38400  = 2604;
    localparam int B19200  = 5208;
    localparam int B9600   = 10416;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_RECV  = 3'd2,
        RX_PAR   = 3'd3,
        RX_STOP  = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input that idles high; both flops
// reset to 1 so a reset never looks like a falling edge downstream.
module uart_rx_sync (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Samples mid-bit with an inline divisor; pulses rcv/ferr/perr once per frame.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUD = B9600
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv,
    output logic       busy,
    output logic       ferr,
    output logic       perr
);

    localparam int CW = $clog2(BAUD);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD - 1);
    localparam logic [3:0]    LAST_BIT = 4'(UART_DATA_BITS - 1);

    logic                      rx_s;
    rx_state_t                 state;
    logic [CW-1:0]             div_cnt;
    logic [3:0]                bitc;
    logic [UART_DATA_BITS-1:0] shifter;
    logic                      div_end;
    logic                      par_ok;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (rx),
        .q    (rx_s)
    );

    assign div_end = (div_cnt == FULL_M1);

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    // Even parity over data plus parity bit
    assign par_ok = ~(^{shifter, par_bit});

    always_ff @(posedge clk) begin
        if (state == RX_PAR && div_end)
            par_bit <= rx_s;
    end
`else
    assign par_ok = 1'b1;
    assign perr   = 1'b0;
`endif

    // LSB arrives first, so shifting in at the MSB leaves the byte in order
    always_ff @(posedge clk) begin
        if (state == RX_RECV && div_end)
            shifter <= {rx_s, shifter[UART_DATA_BITS-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= RX_IDLE;
            div_cnt <= '0;
            bitc    <= '0;
            data    <= '0;
            rcv     <= 1'b0;
            ferr    <= 1'b0;
            busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr    <= 1'b0;
`endif
        end else begin
            rcv     <= 1'b0;
            ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr    <= 1'b0;
`endif
            busy    <= (state != RX_IDLE);
            div_cnt <= div_end ? '0 : div_cnt + 1'b1;

            case (state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state   <= RX_START;
                        div_cnt <= '0;
                    end
                end
                // Half-period wait lands every later sample at mid-bit
                RX_START: begin
                    if (div_cnt == HALF_M1) begin
                        div_cnt <= '0;
                        if (!rx_s) begin
                            state <= RX_RECV;
                            bitc  <= '0;
                        end else begin
                            state <= RX_IDLE;
                        end
                    end
                end
                RX_RECV: begin
                    if (div_end) begin
                        bitc <= bitc + 4'd1;
                        if (bitc == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= RX_PAR;
`else
                            state <= RX_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                RX_PAR: begin
                    if (div_end)
                        state <= RX_STOP;
                end
`endif
                // Leaving at mid-stop-bit lets a back-to-back start edge be caught
                RX_STOP: begin
                    if (div_end) begin
                        state <= RX_IDLE;
                        if (!rx_s) begin
                            ferr <= 1'b1;
                        end else if (!par_ok) begin
`ifdef UART_RX_PARITY_EN
                            perr <= 1'b1;
`endif
                        end else begin
                            data <= shifter;
                            rcv  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= RX_IDLE;
                    div_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BAUD = 16; follows UART_RX_PARITY_EN when defined.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int BAUD = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int LAT    = 2 + BAUD / 2 + (NBITS - 1) * BAUD;
    localparam int PERIOD = NBITS * BAUD;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       rcv, busy, ferr, perr;

    uart_rx #(.BAUD(BAUD)) dut (
        .clk  (clk),
        .rstn (rstn),
        .rx   (rx),
        .data (data),
        .rcv  (rcv),
        .busy (busy),
        .ferr (ferr),
        .perr (perr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int t0 = 0;
    int n_rcv = 0, n_ferr = 0, n_perr = 0, n_multi = 0;
    int last_pulse_cyc = 0;
    int         rcv_cyc_q[$];
    logic [7:0] rcv_data_q[$];

    always @(negedge clk) begin
        if (rcv) begin
            n_rcv++;
            rcv_cyc_q.push_back(cyc);
            rcv_data_q.push_back(data);
        end
        if (ferr) n_ferr++;
        if (perr) n_perr++;
        if (rcv || ferr || perr) last_pulse_cyc = cyc;
        if (int'(rcv) + int'(ferr) + int'(perr) > 1) n_multi++;
    end

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       par_bad;
        logic       exp_rcv;
        logic       exp_ferr;
        logic       exp_perr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BAUD) @(negedge clk);
    endtask

    // Caller must be at a negedge; the next posedge is cycle 0 of the frame
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_bad);
        t0 = cyc + 1;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_bad);
`endif
        send_bit(stop);
        rx = 1'b1;
    endtask

    initial begin
        int r0, f0, p0, t0a;

        vecs.push_back('{8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55});
        vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF});
        vecs.push_back('{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF});
        vecs.push_back('{8'hC9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC9});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h07});
        vecs.push_back('{8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h07});
        vecs.push_back('{8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h07});
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_data", data, 8'h00);
        check("reset_rcv", rcv, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_ferr", ferr, 1'b0);
        check("reset_perr", perr, 1'b0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_busy", busy, 1'b0);

        // Table of single frames
        foreach (vecs[k]) begin
            r0 = n_rcv; f0 = n_ferr; p0 = n_perr;
            send_frame(vecs[k].d, vecs[k].stop, vecs[k].par_bad);
            repeat (2 * BAUD) @(negedge clk);
            check($sformatf("v%0d_rcv", k), n_rcv - r0, 32'(vecs[k].exp_rcv));
            check($sformatf("v%0d_ferr", k), n_ferr - f0, 32'(vecs[k].exp_ferr));
            check($sformatf("v%0d_perr", k), n_perr - p0, 32'(vecs[k].exp_perr));
            check($sformatf("v%0d_data", k), data, vecs[k].exp_data);
            if (vecs[k].exp_rcv || vecs[k].exp_ferr || vecs[k].exp_perr)
                check($sformatf("v%0d_latency", k), last_pulse_cyc - t0, LAT);
        end

        // Back-to-back frames with no idle gap
        rcv_cyc_q.delete();
        rcv_data_q.delete();
        send_frame(8'hA3, 1'b1, 1'b0);
        t0a = t0;
        send_frame(8'h0F, 1'b1, 1'b0);
        repeat (2 * BAUD) @(negedge clk);
        check("b2b_count", rcv_cyc_q.size(), 2);
        if (rcv_cyc_q.size() == 2) begin
            check("b2b_first_lat", rcv_cyc_q[0] - t0a, LAT);
            check("b2b_spacing", rcv_cyc_q[1] - rcv_cyc_q[0], PERIOD);
            check("b2b_data0", rcv_data_q[0], 8'hA3);
            check("b2b_data1", rcv_data_q[1], 8'h0F);
        end

        // Glitch: 4 low cycles must be rejected
        r0 = n_rcv; f0 = n_ferr; p0 = n_perr;
        t0 = cyc + 1;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        check("glitch_busy_c2", busy, 1'b0);
        @(negedge clk);
        check("glitch_busy_c3", busy, 1'b1);
        rx = 1'b1;
        repeat (9) @(negedge clk);
        check("glitch_cycle", cyc - t0, 12);
        check("glitch_busy_c12", busy, 1'b0);
        repeat (12 * BAUD) @(negedge clk);
        check("glitch_pulses", (n_rcv - r0) + (n_ferr - f0) + (n_perr - p0), 0);

        // Reset in the middle of data bit 4 of 0x81
        r0 = n_rcv; f0 = n_ferr; p0 = n_perr;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        rx = 1'b0;
        repeat (BAUD / 2) @(negedge clk);
        check("midrst_busy_before", busy, 1'b1);
        rstn = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        check("midrst_data", data, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_rcv", rcv, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (12 * BAUD) @(negedge clk);
        check("midrst_pulses", (n_rcv - r0) + (n_ferr - f0) + (n_perr - p0), 0);
        check("midrst_idle_busy", busy, 1'b0);
        r0 = n_rcv;
        send_frame(8'h81, 1'b1, 1'b0);
        repeat (2 * BAUD) @(negedge clk);
        check("after_rst_rcv", n_rcv - r0, 1);
        check("after_rst_data", data, 8'h81);
        check("after_rst_latency", last_pulse_cyc - t0, LAT);

        check("pulses_exclusive", n_multi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
